neuron_state_reader: RTL

Read-side sequencer for the bank of 21-bit signed neuron state registers, which are loaded by the per-register `set` strobe.
- On `start`, it takes a snapshot of all N register outputs in one cycle.
- It then streams the N values out one per valid/ready handshake, each tagged with its index.
- It sits between the neuron register bank and the host/readout path. It never writes the bank.

---
 rtl/neuron_pkg.sv | 23 ++
 rtl/neuron_state_reader_sat_narrow.sv | 33 +++
 rtl/neuron_state_reader.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/neuron_pkg.sv
// Shared definitions for the neuron state read path.
//   NEURON_DATA_W : width of one signed neuron state register
//   rd_state_e    : reader sequencer states (IDLE, SEND)
//   sat_max/min   : signed range limits of an out_w-bit two's-complement value,
//                   used to build the saturation bounds of sat_narrow
package neuron_pkg;

  localparam int NEURON_DATA_W = 21;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } rd_state_e;

  function automatic int sat_max(input int out_w);
    return (1 << (out_w - 1)) - 1;
  endfunction

  function automatic int sat_min(input int out_w);
    return -(1 << (out_w - 1));
  endfunction

endpackage

// File: rtl/neuron_state_reader_sat_narrow.sv
// sat_narrow: purely combinational signed saturation from DATA_W to OUT_W bits.
// Ports:
//   in_i   [DATA_W] signed input value
//   out_o  [OUT_W]  signed value clamped to [-(2**(OUT_W-1)), 2**(OUT_W-1)-1]
//   clip_o          high when in_i was outside that range
module sat_narrow
  import neuron_pkg::*;
#(
  parameter int DATA_W = NEURON_DATA_W,
  parameter int OUT_W  = 16
) (
  input  logic signed [DATA_W-1:0] in_i,
  output logic signed [OUT_W-1:0]  out_o,
  output logic                     clip_o
);

  localparam logic signed [DATA_W-1:0] MAX_V = DATA_W'(sat_max(OUT_W));
  localparam logic signed [DATA_W-1:0] MIN_V = DATA_W'(sat_min(OUT_W));

  function automatic logic signed [OUT_W-1:0] saturate(input logic signed [DATA_W-1:0] v);
    if (v > MAX_V)      return OUT_W'(MAX_V);
    else if (v < MIN_V) return OUT_W'(MIN_V);
    else                return OUT_W'(v);
  endfunction

  function automatic logic clipped(input logic signed [DATA_W-1:0] v);
    return (v > MAX_V) || (v < MIN_V);
  endfunction

  assign out_o  = saturate(in_i);
  assign clip_o = clipped(in_i);

endmodule

// File: rtl/neuron_state_reader.sv
// neuron_state_reader: snapshot all N neuron state registers on start, then
// stream them out one element per valid/ready handshake, tagged with index.
// The register bank is only read, never written.
// Optional build macro READ_SAT_EN: out_data narrows to OUT_W with signed
// saturation and a sat_flag output is added. Without it values pass bit-exact.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   start         snapshot-and-stream request, honoured only when idle
//   reg_bus       flattened register outputs, element i at [i*DATA_W +: DATA_W]
//   out_valid     out_data/out_idx/out_last valid
//   out_ready     consumer accept
//   out_data      signed element value (OUT_W wide under READ_SAT_EN)
//   sat_flag      element was clipped (READ_SAT_EN only)
//   out_idx       element index 0..N-1
//   out_last      high with element N-1
//   busy          stream in progress
//   done          one-cycle pulse after the final handshake
module neuron_state_reader
  import neuron_pkg::*;
#(
  parameter int N      = 8,
  parameter int DATA_W = NEURON_DATA_W,
  parameter int IDX_W  = 8,
  parameter int OUT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [N*DATA_W-1:0]      reg_bus,
  output logic                     out_valid,
  input  logic                     out_ready,
`ifdef READ_SAT_EN
  output logic signed [OUT_W-1:0]  out_data,
  output logic                     sat_flag,
`else
  output logic signed [DATA_W-1:0] out_data,
`endif
  output logic [IDX_W-1:0]         out_idx,
  output logic                     out_last,
  output logic                     busy,
  output logic                     done
);

  // Elaboration-time sanity on the configuration.
  if (N < 1 || N > 2**IDX_W) begin : g_bad_idx_w
    $error("neuron_state_reader: N must be in 1..2**IDX_W");
  end
  if (OUT_W < 2 || OUT_W > DATA_W) begin : g_bad_out_w
    $error("neuron_state_reader: OUT_W must be in 2..DATA_W");
  end

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  rd_state_e             state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  done_q, done_d;
  logic                  snap_load;
  logic [N*DATA_W-1:0]   snap_q;
  logic signed [DATA_W-1:0] elem;

  // Control registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  // Snapshot data register: loaded only on an accepted start, no reset needed.
  always_ff @(posedge clk) begin
    if (snap_load) begin
      snap_q <= reg_bus;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    done_d    = 1'b0;
    snap_load = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = SEND;
          idx_d     = '0;
          snap_load = 1'b1;
        end
      end
      SEND: begin
        if (out_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Select the current element from the frozen snapshot.
  always_comb begin
    elem = '0;
    for (int i = 0; i < N; i++) begin
      if (idx_q == IDX_W'(i)) begin
        elem = snap_q[i*DATA_W +: DATA_W];
      end
    end
  end

  assign out_valid = (state_q == SEND);
  assign busy      = out_valid;
  // idx_q parks at N-1 after a stream; outputs are forced to zero when idle.
  assign out_idx   = out_valid ? idx_q : '0;
  assign out_last  = out_valid && (idx_q == LAST_IDX);
  assign done      = done_q;

`ifdef READ_SAT_EN
  logic signed [OUT_W-1:0] sat_data;
  logic                    sat_clip;

  sat_narrow #(
    .DATA_W (DATA_W),
    .OUT_W  (OUT_W)
  ) u_sat_narrow (
    .in_i   (elem),
    .out_o  (sat_data),
    .clip_o (sat_clip)
  );

  assign out_data = out_valid ? sat_data : '0;
  assign sat_flag = out_valid & sat_clip;
`else
  assign out_data = out_valid ? elem : '0;
`endif

endmodule
